vga_sync_receiver: RTL
======================

# vga_sync_receiver

Pixel-stream receiver for the 640x480 VGA display path: consumes the hSync/vSync/12-bit RGB stream produced by the display controller and recovers pixel coordinates, per-pixel valid strobes and frame boundaries. It checks line and frame lengths against the programmed timing and declares lock only after consecutive well-formed frames. Used as the on-chip loopback checker and frame-capture front end for the game display.

## Interface
Parameters:
- WIDTH, 640, visible pixels per line
- HEIGHT, 480, visible lines per frame
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync lengths in pixels
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync lengths in lines
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  one-clk strobe per pixel period (25 MHz, every 4th clk)
- hSync  in  1  horizontal sync, active low
- vSync  in  1  vertical sync, active low
- rgb  in  12  {R,G,B} 4 bits each
- x  out  10  recovered column, 0..WIDTH-1
- y  out  9  recovered row, 0..HEIGHT-1
- pixel  out  12  rgb captured with current x,y
- pixel_valid  out  1  one-clk pulse per visible pixel while locked
- frame_start  out  1  one-clk pulse coincident with pixel_valid at (0,0)
- locked  out  1  timing lock indicator
- line_err  out  1  one-clk pulse on bad line length
- frame_err  out  1  one-clk pulse on bad frame length
- frame_count  out  16  good frames received while locked, wraps

## Operation
- H_TOTAL = WIDTH+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = HEIGHT+V_FRONT+V_SYNC+V_BACK (525).
- hSync, vSync, rgb sampled only on clk edges with pix_en=1; all state held otherwise.
- Falling edge = previous sample 1, current sample 0 (previous-sample regs reset to 1).
- hcnt (10 b): 0 on hSync fall, else increment, saturate at 1023.
- vcnt (10 b): 0 on vSync fall (priority over hSync fall in same sample); else +1 on hSync fall, saturate at 1023.
- Visible region: hcnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+WIDTH-1] (144..783) and vcnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+HEIGHT-1] (35..514); x = hcnt-144, y = vcnt-35.
- Line check: on hSync fall, if h_seen and old hcnt != H_TOTAL-1, pulse line_err. h_seen set by first hSync fall.
- Frame check: on vSync fall, if v_seen and old vcnt != V_TOTAL-1, pulse frame_err; else frame is good. v_seen set by first vSync fall.
- A frame with any line_err is bad even if its length is correct.
- FSM: UNLOCKED (reset) -> SYNCING on first vSync fall. SYNCING: good frame increments good_cnt; bad frame clears it; good_cnt == LOCK_FRAMES -> LOCKED. LOCKED: good frame increments frame_count; any line_err or frame_err -> SYNCING, good_cnt=0, locked drops the same edge.
- pixel_valid, frame_start only in LOCKED; never during errors.

## Timing
- Reset values: x=0, y=0, pixel=0, pixel_valid=0, frame_start=0, locked=0, line_err=0, frame_err=0, frame_count=0, hcnt=vcnt=0, h_seen=v_seen=0, FSM=UNLOCKED.
- Counters, x, y, pixel update on the pix_en edge using the new counter value; x/y/pixel hold until the next pix_en edge. Outside the visible region x=y=0.
- pixel_valid, frame_start, line_err, frame_err are high for exactly the clk following the pix_en edge that produced them.
- locked rises on the edge at which the LOCK_FRAMES-th good vSync fall is sampled; the next visible pixel is the first valid one.
- Reset asserted mid-frame: all state cleared immediately; relock requires first vSync fall plus LOCK_FRAMES good frames.
- Missing syncs: counters saturate at 1023; next fall then reports an error.

## Test plan
- Ideal 800x525 stream, rgb = {x[3:0],y[3:0],4'h5}: locked after 2nd good vSync fall following first; next frame gives 307200 pixel_valid pulses, first at x=0,y=0 with frame_start, last at x=639,y=479, pixel matches rgb.
- One 799-pixel line while locked: line_err pulse at next hSync fall, locked drops same edge, relocks after 2 good frames; frame_count unchanged during relock.
- 524-line frame: frame_err at vSync fall, locked=0, no pixel_valid until relock.
- pix_en held low for 1000 clks mid-line with syncs toggling: no state change, no pulses.
- reset asserted for 1 clk mid-frame while locked: all outputs return to reset values asynchronously; lock regained after 3 vSync falls.
- 65536+1 good frames locked: frame_count wraps to 1.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
// Recovers pixel coordinates, per-pixel valid strobes and frame boundaries
// from an hSync/vSync/RGB pixel stream, checks line and frame lengths against
// the programmed timing and declares lock after consecutive good frames.
module vga_sync_receiver #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [11:0] rgb,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic [11:0] pixel,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        line_err,
  output logic        frame_err,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_FIRST = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_VIS_LAST  = 10'(H_SYNC + H_BACK + WIDTH - 1);
  localparam logic [9:0] V_VIS_FIRST = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_VIS_LAST  = 10'(V_SYNC + V_BACK + HEIGHT - 1);
  localparam logic [9:0] CNT_MAX     = 10'h3FF;
  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_FRAMES);

  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] SYNCING  = 2'd1;
  localparam logic [1:0] LOCKED   = 2'd2;

  logic       hPrev, vPrev;
  logic [9:0] hCnt, vCnt;
  logic [9:0] hCntNext, vCntNext;
  logic       hSeen, vSeen;
  logic       lineBad;
  logic [1:0] state, stateNext;
  logic [3:0] goodCnt, goodCntNext;
  logic       countFrame;

  logic       hFall, vFall;
  logic       lineErrNow;
  logic       frameChecked, frameLenBad, frameGood, frameBadNow;
  logic       visible;
  logic [9:0] xNext;
  logic [8:0] yNext;

  assign hFall = hPrev & ~hSync;
  assign vFall = vPrev & ~vSync;

  // A line is judged when the next one starts; the very first hSync fall only arms the check.
  assign lineErrNow   = hFall & hSeen & (hCnt != H_LAST);
  assign frameChecked = vFall & vSeen;
  assign frameLenBad  = frameChecked & (vCnt != V_LAST);
  // The closing line of a frame is checked on the same sample as the vSync fall, so it counts too.
  assign frameGood    = frameChecked & ~frameLenBad & ~lineBad & ~lineErrNow;
  assign frameBadNow  = frameChecked & ~frameGood;

  assign visible = (hCntNext >= H_VIS_FIRST) && (hCntNext <= H_VIS_LAST) &&
                   (vCntNext >= V_VIS_FIRST) && (vCntNext <= V_VIS_LAST);
  assign xNext   = hCntNext - H_VIS_FIRST;
  assign yNext   = 9'(vCntNext - V_VIS_FIRST);

  assign locked = (state == LOCKED);

  // Next raster position: sync falls restart the counters, otherwise they saturate at 1023.
  always_comb begin
    hCntNext = hCnt;
    vCntNext = vCnt;
    if (hFall) begin
      hCntNext = '0;
    end else if (hCnt != CNT_MAX) begin
      hCntNext = hCnt + 10'd1;
    end
    if (vFall) begin
      vCntNext = '0;
    end else if (hFall && (vCnt != CNT_MAX)) begin
      vCntNext = vCnt + 10'd1;
    end
  end

  // Lock state machine: any error while locked falls back to counting good frames again.
  always_comb begin
    stateNext   = state;
    goodCntNext = goodCnt;
    countFrame  = 1'b0;
    case (state)
      UNLOCKED: begin
        if (vFall) begin
          stateNext   = SYNCING;
          goodCntNext = '0;
        end
      end
      SYNCING: begin
        if (frameGood) begin
          if (4'(goodCnt + 4'd1) == LOCK_TARGET) begin
            stateNext   = LOCKED;
            goodCntNext = '0;
          end else begin
            goodCntNext = goodCnt + 4'd1;
          end
        end else if (frameBadNow) begin
          goodCntNext = '0;
        end
      end
      LOCKED: begin
        if (lineErrNow || frameLenBad) begin
          stateNext   = SYNCING;
          goodCntNext = '0;
        end else if (frameGood) begin
          countFrame = 1'b1;
        end
      end
      default: begin
        stateNext   = UNLOCKED;
        goodCntNext = '0;
      end
    endcase
  end

  // Sample the sync inputs and advance the raster counters once per pixel period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hPrev   <= 1'b1;
      vPrev   <= 1'b1;
      hCnt    <= '0;
      vCnt    <= '0;
      hSeen   <= 1'b0;
      vSeen   <= 1'b0;
      lineBad <= 1'b0;
    end else if (pix_en) begin
      hPrev <= hSync;
      vPrev <= vSync;
      hCnt  <= hCntNext;
      vCnt  <= vCntNext;
      hSeen <= hSeen | hFall;
      vSeen <= vSeen | vFall;
      if (vFall) begin
        lineBad <= 1'b0;
      end else if (lineErrNow) begin
        lineBad <= 1'b1;
      end
    end
  end

  // Lock state, good-frame run length and the locked frame counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= UNLOCKED;
      goodCnt     <= '0;
      frame_count <= '0;
    end else if (pix_en) begin
      state   <= stateNext;
      goodCnt <= goodCntNext;
      if (countFrame) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Coordinate/pixel capture and single-clk strobes, all produced from the new raster position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      if (pix_en) begin
        pixel     <= rgb;
        line_err  <= lineErrNow;
        frame_err <= frameLenBad;
        if (visible) begin
          x           <= xNext;
          y           <= yNext;
          pixel_valid <= (stateNext == LOCKED);
          frame_start <= (stateNext == LOCKED) && (xNext == '0) && (yNext == '0);
        end else begin
          x <= '0;
          y <= '0;
        end
      end
    end
  end

endmodule
